// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - two-channel round-robin UDP payload arbiter in front of eth_mac
//
// Grants one of two byte-wide payload streams at a time onto the eth_mac input,
// drives the per-frame UDP/IP header fields for the granted frame, checks the
// payload length against tlast and enforces an inter-frame gap between grants.
//
// Ports:
//   sys_clk, rst                        clock, asynchronous active-high reset
//   chN_tdata/tvalid/tlast/tready       payload stream from channel N (tvalid doubles as request)
//   chN_len, chN_dst_port               frame length and destination port, sampled at grant
//   m_axis_tdata/tvalid/tlast/tuser     stream to eth_mac (tuser tied low)
//   m_axis_tready                       backpressure from eth_mac
//   IP_TotLen, UDP_TotLen               len+28 / len+8, held for the frame
//   UDP_SrcPort, UDP_DestPort           SRC_PORT_BASE+channel / sampled destination port
//   busy, grant, len_err                not-idle flag, granted channel, length error pulse
`timescale 1ns/1ps
module udp_tx_arbiter #(
    parameter logic [15:0] SRC_PORT_BASE = 16'd5000,
    parameter int          HDR_SETUP     = 4,
    parameter int          IFG_CYCLES    = 64,
    parameter int          MAX_LEN       = 1472
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [7:0]  ch0_tdata,
    input  logic        ch0_tvalid,
    input  logic        ch0_tlast,
    output logic        ch0_tready,
    input  logic [15:0] ch0_len,
    input  logic [15:0] ch0_dst_port,
    input  logic [7:0]  ch1_tdata,
    input  logic        ch1_tvalid,
    input  logic        ch1_tlast,
    output logic        ch1_tready,
    input  logic [15:0] ch1_len,
    input  logic [15:0] ch1_dst_port,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [15:0] IP_TotLen,
    output logic [15:0] UDP_TotLen,
    output logic [15:0] UDP_SrcPort,
    output logic [15:0] UDP_DestPort,
    output logic        busy,
    output logic        grant,
    output logic        len_err
);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, DRAIN, GAP} state_t;

    state_t      state;
    logic        rr_last;
    logic [15:0] len_q;
    logic [15:0] byte_cnt;
    logic [7:0]  cnt;

    logic [7:0]  sel_tdata;
    logic        sel_tvalid;
    logic        sel_tlast;
    logic        in_xfer;
    logic        last_beat;
    logic        src_ready;
    logic        m_hs;
    logic        win;
    logic [15:0] win_len;
    logic [15:0] win_dst;
    logic        len_bad;

    // Granted channel mux; grant is stable for the whole frame.
    assign sel_tdata  = grant ? ch1_tdata  : ch0_tdata;
    assign sel_tvalid = grant ? ch1_tvalid : ch0_tvalid;
    assign sel_tlast  = grant ? ch1_tlast  : ch0_tlast;

    assign in_xfer   = (state == XFER);
    assign last_beat = (byte_cnt == len_q - 16'd1);

    // Payload passes straight through; tlast is forced at the programmed length
    // and also follows an early source tlast.
    assign m_axis_tvalid = in_xfer & sel_tvalid;
    assign m_axis_tdata  = in_xfer ? sel_tdata : 8'd0;
    assign m_axis_tlast  = in_xfer & sel_tvalid & (last_beat | sel_tlast);
    assign m_axis_tuser  = 1'b0;
    assign m_hs          = m_axis_tvalid & m_axis_tready;

    // DRAIN accepts unconditionally so a discarded frame cannot block the arbiter.
    assign src_ready  = in_xfer ? m_axis_tready : (state == DRAIN);
    assign ch0_tready = src_ready & ~grant;
    assign ch1_tready = src_ready & grant;

    assign busy = (state != IDLE);

    // With both requesting, the channel that did not win last time goes next.
    assign win     = (ch0_tvalid & ch1_tvalid) ? ~rr_last : ch1_tvalid;
    assign win_len = win ? ch1_len : ch0_len;
    assign win_dst = win ? ch1_dst_port : ch0_dst_port;
    assign len_bad = (win_len == 16'd0) || (win_len > 16'(MAX_LEN));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_last      <= 1'b1;
            grant        <= 1'b0;
            len_err      <= 1'b0;
            IP_TotLen    <= 16'd0;
            UDP_TotLen   <= 16'd0;
            UDP_SrcPort  <= 16'd0;
            UDP_DestPort <= 16'd0;
            len_q        <= 16'd0;
            byte_cnt     <= 16'd0;
            cnt          <= 8'd0;
        end else begin
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ch0_tvalid | ch1_tvalid) begin
                        grant    <= win;
                        rr_last  <= win;
                        len_q    <= win_len;
                        byte_cnt <= 16'd0;
                        cnt      <= 8'd0;
                        if (len_bad) begin
                            // Rejected frame: headers keep their previous values.
                            len_err <= 1'b1;
                            state   <= DRAIN;
                        end else begin
                            IP_TotLen    <= win_len + 16'd28;
                            UDP_TotLen   <= win_len + 16'd8;
                            UDP_SrcPort  <= SRC_PORT_BASE + {15'd0, win};
                            UDP_DestPort <= win_dst;
                            state        <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == 8'(HDR_SETUP - 1)) begin
                        cnt   <= 8'd0;
                        state <= XFER;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                XFER: begin
                    if (m_hs) begin
                        byte_cnt <= byte_cnt + 16'd1;
                        if (last_beat) begin
                            // Source longer than declared: throw away the rest.
                            if (!sel_tlast) begin
                                len_err <= 1'b1;
                                state   <= DRAIN;
                            end else begin
                                state <= GAP;
                            end
                        end else if (sel_tlast) begin
                            len_err <= 1'b1;
                            state   <= GAP;
                        end
                    end
                end
                DRAIN: begin
                    if (sel_tvalid & sel_tlast) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt == 8'(IFG_CYCLES - 1)) begin
                        cnt   <= 8'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - self-checking bench for udp_tx_arbiter
`timescale 1ns/1ps
module tb_udp_tx_arbiter;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [7:0]  ch0_tdata, ch1_tdata;
    logic        ch0_tvalid, ch1_tvalid, ch0_tlast, ch1_tlast;
    logic        ch0_tready, ch1_tready;
    logic [15:0] ch0_len, ch1_len, ch0_dst_port, ch1_dst_port;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic [15:0] IP_TotLen, UDP_TotLen, UDP_SrcPort, UDP_DestPort;
    logic        busy, grant, len_err;

    udp_tx_arbiter dut (
        .sys_clk(sys_clk), .rst(rst),
        .ch0_tdata(ch0_tdata), .ch0_tvalid(ch0_tvalid), .ch0_tlast(ch0_tlast),
        .ch0_tready(ch0_tready), .ch0_len(ch0_len), .ch0_dst_port(ch0_dst_port),
        .ch1_tdata(ch1_tdata), .ch1_tvalid(ch1_tvalid), .ch1_tlast(ch1_tlast),
        .ch1_tready(ch1_tready), .ch1_len(ch1_len), .ch1_dst_port(ch1_dst_port),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .IP_TotLen(IP_TotLen), .UDP_TotLen(UDP_TotLen),
        .UDP_SrcPort(UDP_SrcPort), .UDP_DestPort(UDP_DestPort),
        .busy(busy), .grant(grant), .len_err(len_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          ld0;
        int          n0;
        logic [15:0] len0, dst0;
        bit          ld1;
        int          n1;
        logic [15:0] len1, dst1;
        bit          tog;
        int          exp_g;
        bit          hdr;
        logic [15:0] exp_ip, exp_udp, exp_src, exp_dst;
        int          exp_beats, exp_last, exp_err;
    } vec_t;

    vec_t vecs[13];

    int total = 0;
    int bad   = 0;

    // Source models: channel c holds n[c] bytes, base[c]+i, tlast on the last one.
    int          n[2], ptr[2];
    bit          en[2];
    logic [15:0] slen[2], sdst[2];
    logic [7:0]  base[2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_src();
        ch0_tvalid   = en[0] && (ptr[0] < n[0]);
        ch0_tdata    = base[0] + 8'(ptr[0]);
        ch0_tlast    = (ptr[0] == n[0] - 1);
        ch0_len      = slen[0];
        ch0_dst_port = sdst[0];
        ch1_tvalid   = en[1] && (ptr[1] < n[1]);
        ch1_tdata    = base[1] + 8'(ptr[1]);
        ch1_tlast    = (ptr[1] == n[1] - 1);
        ch1_len      = slen[1];
        ch1_dst_port = sdst[1];
    endtask

    function automatic vec_t mk(input bit ld0, input int n0, input int len0, input int dst0,
                                input bit ld1, input int n1, input int len1, input int dst1,
                                input bit tog, input int g, input bit hdr,
                                input int ip, input int udp, input int src, input int dst,
                                input int beats, input int last, input int err);
        vec_t v;
        v.ld0 = ld0; v.n0 = n0; v.len0 = 16'(len0); v.dst0 = 16'(dst0);
        v.ld1 = ld1; v.n1 = n1; v.len1 = 16'(len1); v.dst1 = 16'(dst1);
        v.tog = tog; v.exp_g = g; v.hdr = hdr;
        v.exp_ip = 16'(ip); v.exp_udp = 16'(udp); v.exp_src = 16'(src); v.exp_dst = 16'(dst);
        v.exp_beats = beats; v.exp_last = last; v.exp_err = err;
        return v;
    endfunction

    // Runs one frame from IDLE through GAP and checks everything observed.
    task automatic run_vec(input vec_t v, input int vi);
        int cyc = 0, k = 0, beats = 0, tvc = 0, lastpos = 0, nlast = 0, errs = 0;
        int dbad = 0, hbad = 0, first = -1, lasths = -1, lastbusy = -1, g = 0;
        bit started = 0, done = 0, hs0, hs1, mhs;
        logic [15:0] ip0 = 0, udp0 = 0, src0 = 0, dst0 = 0;
        if (v.ld0) begin
            n[0] = v.n0; ptr[0] = 0; slen[0] = v.len0; sdst[0] = v.dst0; base[0] = 8'(vi * 16);
        end
        if (v.ld1) begin
            n[1] = v.n1; ptr[1] = 0; slen[1] = v.len1; sdst[1] = v.dst1; base[1] = 8'(128 + vi * 16);
        end
        en[0] = (ptr[0] < n[0]);
        en[1] = (ptr[1] < n[1]);
        m_axis_tready = 1'b1;
        apply_src();
        while (!done && cyc < 600) begin
            @(negedge sys_clk);
            cyc++;
            if (len_err) errs++;
            hs0 = ch0_tvalid & ch0_tready;
            hs1 = ch1_tvalid & ch1_tready;
            mhs = m_axis_tvalid & m_axis_tready;
            if (busy) begin
                if (!started) begin
                    started = 1; g = int'(grant);
                    ip0 = IP_TotLen; udp0 = UDP_TotLen; src0 = UDP_SrcPort; dst0 = UDP_DestPort;
                end else if (IP_TotLen != ip0 || UDP_TotLen != udp0 || UDP_SrcPort != src0 ||
                             UDP_DestPort != dst0 || int'(grant) != g) begin
                    hbad++;
                end
                if (m_axis_tvalid) tvc++;
                if (mhs) begin
                    beats++;
                    if (first < 0) first = k;
                    if (m_axis_tdata != base[g] + 8'(beats - 1)) dbad++;
                    if (m_axis_tlast) begin
                        nlast++;
                        if (lastpos == 0) lastpos = beats;
                    end
                end
                if (g == 1 ? hs1 : hs0) lasths = k;
                lastbusy = k;
                k++;
            end else if (started) begin
                done = 1;
            end
            @(posedge sys_clk);
            #1;
            if (hs0) ptr[0]++;
            if (hs1) ptr[1]++;
            // The losing channel is held back so the next grant is set up by the next vector.
            if (started) en[g == 1 ? 0 : 1] = 0;
            m_axis_tready = !v.tog || (k % 2 == 0);
            apply_src();
        end
        chk($sformatf("v%0d_done", vi), int'(done), 1);
        chk($sformatf("v%0d_grant", vi), g, v.exp_g);
        if (v.hdr) begin
            chk($sformatf("v%0d_ip_totlen", vi), int'(ip0), int'(v.exp_ip));
            chk($sformatf("v%0d_udp_totlen", vi), int'(udp0), int'(v.exp_udp));
            chk($sformatf("v%0d_src_port", vi), int'(src0), int'(v.exp_src));
            chk($sformatf("v%0d_dst_port", vi), int'(dst0), int'(v.exp_dst));
        end
        chk($sformatf("v%0d_beats", vi), beats, v.exp_beats);
        chk($sformatf("v%0d_tlast_pos", vi), lastpos, v.exp_last);
        chk($sformatf("v%0d_tlast_cnt", vi), nlast, v.exp_beats > 0 ? 1 : 0);
        chk($sformatf("v%0d_len_err", vi), errs, v.exp_err);
        chk($sformatf("v%0d_data_bad", vi), dbad, 0);
        chk($sformatf("v%0d_hdr_unstable", vi), hbad, 0);
        chk($sformatf("v%0d_consumed", vi), ptr[g], n[g]);
        chk($sformatf("v%0d_gap", vi), lastbusy - lasths, 64);
        if (v.exp_beats > 0) chk($sformatf("v%0d_first_beat", vi), first, 4);
        else                 chk($sformatf("v%0d_tvalid_cycles", vi), tvc, 0);
    endtask

    initial begin
        bit seen;
        vecs[0]  = mk(1, 10, 10, 1234, 0, 0, 0, 0,   0, 0, 1, 38, 18, 5000, 1234, 10, 10, 0);
        vecs[1]  = mk(1, 4, 4, 100,    1, 4, 4, 200, 0, 1, 1, 32, 12, 5001, 200,  4, 4, 0);
        vecs[2]  = mk(0, 0, 0, 0,      1, 4, 4, 201, 0, 0, 1, 32, 12, 5000, 100,  4, 4, 0);
        vecs[3]  = mk(1, 4, 4, 101,    0, 0, 0, 0,   0, 1, 1, 32, 12, 5001, 201,  4, 4, 0);
        vecs[4]  = mk(0, 0, 0, 0,      0, 0, 0, 0,   0, 0, 1, 32, 12, 5000, 101,  4, 4, 0);
        vecs[5]  = mk(0, 0, 0, 0,      1, 5, 8, 300, 0, 1, 1, 36, 16, 5001, 300,  5, 5, 1);
        vecs[6]  = mk(1, 9, 6, 400,    0, 0, 0, 0,   0, 0, 1, 34, 14, 5000, 400,  6, 6, 1);
        vecs[7]  = mk(0, 0, 0, 0,      1, 16, 16, 500, 1, 1, 1, 44, 24, 5001, 500, 16, 16, 0);
        vecs[8]  = mk(1, 3, 0, 0,      1, 4, 4, 600, 0, 0, 0, 0, 0, 0, 0,         0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0,      0, 0, 0, 0,   0, 1, 1, 32, 12, 5001, 600,  4, 4, 0);
        vecs[10] = mk(1, 2, 1500, 9,   0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,         0, 0, 1);
        vecs[11] = mk(1, 4, 4, 700,    1, 4, 4, 800, 0, 0, 1, 32, 12, 5000, 700,  4, 4, 0);
        vecs[12] = mk(0, 0, 0, 0,      0, 0, 0, 0,   0, 1, 1, 32, 12, 5001, 800,  4, 4, 0);

        for (int c = 0; c < 2; c++) begin
            n[c] = 0; ptr[c] = 0; en[c] = 0; slen[c] = 0; sdst[c] = 0; base[c] = 0;
        end
        apply_src();
        m_axis_tready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant_err", int'(grant) + int'(len_err), 0);
        chk("rst_m_axis", int'(m_axis_tvalid) + int'(m_axis_tlast) + int'(m_axis_tuser) + int'(m_axis_tdata), 0);
        chk("rst_hdr", int'(IP_TotLen | UDP_TotLen | UDP_SrcPort | UDP_DestPort), 0);
        rst = 1'b0;
        @(posedge sys_clk);
        #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset in the middle of a payload transfer.
        n[0] = 10; ptr[0] = 0; slen[0] = 16'd10; sdst[0] = 16'd77; base[0] = 8'h40; en[0] = 1;
        apply_src();
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge sys_clk);
            if (m_axis_tvalid & m_axis_tready) seen = 1;
        end
        chk("midrst_reached_xfer", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_m_tvalid", int'(m_axis_tvalid), 0);
        chk("midrst_ready", int'(ch0_tready) + int'(ch1_tready), 0);
        chk("midrst_hdr", int'(IP_TotLen | UDP_DestPort), 0);
        en[0] = 0; en[1] = 0;
        apply_src();
        @(posedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        @(posedge sys_clk);
        #1;

        for (int i = 11; i < 13; i++) run_vec(vecs[i], i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
